fifo_wr: RTL and testbench

FIFO_WR -- requirements
Module: fifo_wr

---
 rtl/fifo_wr.sv | 90 +++++++++
 tb/tb_fifo_wr.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fifo_wr.sv
// Write-side control for an asynchronous FIFO: binary/Gray write pointer,
// read-pointer synchronizer, and full / almost-full / level / overflow flags.
module fifo_wr #(
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned AF_LEVEL = DEPTH - 2
) (
   input  logic                     wclk,
   input  logic                     wrst,
   input  logic                     winc,
   input  logic [$clog2(DEPTH):0]   rptr,
   output logic                     wen,
   output logic [$clog2(DEPTH)-1:0] waddr,
   output logic [$clog2(DEPTH):0]   wptr,
   output logic                     wfull,
   output logic                     walmost_full,
   output logic [$clog2(DEPTH):0]   wlevel,
   output logic                     woverflow
);

   localparam int unsigned N  = $clog2(DEPTH);
   localparam int unsigned PW = N + 1;

   logic [PW-1:0] wbin_q, wbin_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rq1_q, rq2_q;
   logic [PW-1:0] wlevel_q, wlevel_d;
   logic [PW-1:0] rbin;
   logic          wfull_q, wfull_d;
   logic          walmost_full_q, walmost_full_d;
   logic          woverflow_q, woverflow_d;

   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return (b >> 1) ^ b;
   endfunction

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = int'(PW) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Reset also gates the strobe so a write presented during reset never lands.
   assign wen   = winc & ~wfull_q & ~wrst;
   assign waddr = wbin_q[N-1:0];

   always_comb begin
      wbin_d         = wbin_q;
      if (wen) begin
         wbin_d = wbin_q + PW'(1);
      end
      wptr_d         = bin2gray(wbin_d);
      rbin           = gray2bin(rq2_q);
      wlevel_d       = wbin_d - rbin;
      wfull_d        = (wptr_d == {~rq2_q[N:N-1], rq2_q[N-2:0]});
      walmost_full_d = (32'(wlevel_d) >= AF_LEVEL);
      woverflow_d    = woverflow_q | (winc & wfull_q);
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         wbin_q         <= '0;
         wptr_q         <= '0;
         rq1_q          <= '0;
         rq2_q          <= '0;
         wlevel_q       <= '0;
         wfull_q        <= 1'b0;
         walmost_full_q <= 1'b0;
         woverflow_q    <= 1'b0;
      end else begin
         wbin_q         <= wbin_d;
         wptr_q         <= wptr_d;
         rq1_q          <= rptr;
         rq2_q          <= rq1_q;
         wlevel_q       <= wlevel_d;
         wfull_q        <= wfull_d;
         walmost_full_q <= walmost_full_d;
         woverflow_q    <= woverflow_d;
      end
   end

   assign wptr         = wptr_q;
   assign wfull        = wfull_q;
   assign walmost_full = walmost_full_q;
   assign wlevel       = wlevel_q;
   assign woverflow    = woverflow_q;

endmodule

// File: tb/tb_fifo_wr.sv
// Directed bench for fifo_wr (DEPTH=8, AF_LEVEL=6) with hand-computed expectations.
module tb_fifo_wr;

   logic       wclk;
   logic       wrst;
   logic       winc;
   logic [3:0] rptr;
   logic       wen;
   logic [2:0] waddr;
   logic [3:0] wptr;
   logic       wfull;
   logic       walmost_full;
   logic [3:0] wlevel;
   logic       woverflow;

   int checks = 0;
   int errors = 0;

   fifo_wr #(.DEPTH(8), .AF_LEVEL(6)) dut (
      .wclk        (wclk),
      .wrst        (wrst),
      .winc        (winc),
      .rptr        (rptr),
      .wen         (wen),
      .waddr       (waddr),
      .wptr        (wptr),
      .wfull       (wfull),
      .walmost_full(walmost_full),
      .wlevel      (wlevel),
      .woverflow   (woverflow)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle away from it.
   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   function automatic logic [3:0] gray(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_wen"},   8'(wen), 8'h0);
      check({tag, "_waddr"}, 8'(waddr), 8'h0);
      check({tag, "_wptr"},  8'(wptr), 8'h0);
      check({tag, "_wfull"}, 8'(wfull), 8'h0);
      check({tag, "_waf"},   8'(walmost_full), 8'h0);
      check({tag, "_wlevel"},8'(wlevel), 8'h0);
      check({tag, "_wovf"},  8'(woverflow), 8'h0);
   endtask

   initial begin
      logic [3:0] k4;
      wrst = 1'b1;
      winc = 1'b1;
      rptr = 4'b0000;

      // Reset with a write requested
      #2;
      check("rst_wen_during", 8'(wen), 8'h0);
      tick();
      wrst = 1'b0;
      winc = 1'b0;
      #1;
      check_all_zero("rst");

      // Fill: 8 consecutive writes with rptr=0
      winc = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         #1;
         check("fill_waddr_pre", 8'(waddr), 8'((k - 1) % 8));
         check("fill_wen_pre", 8'(wen), 8'h1);
         tick();
         k4 = 4'(k);
         check("fill_wlevel", 8'(wlevel), 8'(k));
         check("fill_wptr", 8'(wptr), 8'(gray(k4)));
         check("fill_waf", 8'(walmost_full), (k >= 6) ? 8'h1 : 8'h0);
         check("fill_wfull", 8'(wfull), (k == 8) ? 8'h1 : 8'h0);
      end
      winc = 1'b0;
      #1;
      check("fill_wptr_end", 8'(wptr), 8'hC);
      check("fill_waddr_end", 8'(waddr), 8'h0);

      // Overflow: one write attempt while full
      winc = 1'b1;
      #1;
      check("ovf_wen", 8'(wen), 8'h0);
      tick();
      winc = 1'b0;
      check("ovf_wptr", 8'(wptr), 8'hC);
      check("ovf_flag", 8'(woverflow), 8'h1);
      for (int c = 0; c < 20; c++) begin
         tick();
         check("ovf_sticky", 8'(woverflow), 8'h1);
      end
      check("ovf_wptr_hold", 8'(wptr), 8'hC);

      // Drain latency: rptr advances by one, flags follow on the third edge
      rptr = 4'b0001;
      tick();
      check("drain_e1_wfull", 8'(wfull), 8'h1);
      tick();
      check("drain_e2_wfull", 8'(wfull), 8'h1);
      check("drain_e2_wlevel", 8'(wlevel), 8'h8);
      tick();
      check("drain_e3_wfull", 8'(wfull), 8'h0);
      check("drain_e3_wlevel", 8'(wlevel), 8'h7);
      check("drain_e3_waf", 8'(walmost_full), 8'h1);

      // Refill to full (9th write lands at waddr 0), then reset mid-operation
      winc = 1'b1;
      #1;
      check("refill_waddr", 8'(waddr), 8'h0);
      tick();
      winc = 1'b0;
      check("refill_wfull", 8'(wfull), 8'h1);
      check("refill_wptr", 8'(wptr), 8'hD);
      check("refill_wovf", 8'(woverflow), 8'h1);
      wrst = 1'b1;
      winc = 1'b1;
      tick();
      wrst = 1'b0;
      winc = 1'b0;
      rptr = 4'b0000;
      #1;
      check_all_zero("midrst");
      winc = 1'b1;
      #1;
      check("midrst_next_waddr", 8'(waddr), 8'h0);
      check("midrst_next_wen", 8'(wen), 8'h1);
      tick();
      winc = 1'b0;
      check("midrst_next_wptr", 8'(wptr), 8'h1);
      check("midrst_next_wlevel", 8'(wlevel), 8'h1);

      // Wrap: 16 writes with rptr two writes behind the write pointer
      wrst = 1'b1;
      tick();
      wrst = 1'b0;
      winc = 1'b1;
      for (int k = 0; k < 16; k++) begin
         rptr = (k >= 2) ? gray(4'(k - 2)) : 4'b0000;
         #1;
         check("wrap_waddr", 8'(waddr), 8'(k % 8));
         check("wrap_wen", 8'(wen), 8'h1);
         tick();
         k4 = 4'(k + 1);
         check("wrap_wptr", 8'(wptr), 8'(gray(k4)));
         check("wrap_wfull", 8'(wfull), 8'h0);
      end
      winc = 1'b0;
      check("wrap_wptr_end", 8'(wptr), 8'h0);
      check("wrap_waddr_end", 8'(waddr), 8'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
